// File: rtl/difference_shift_reg_if.sv
// Bus between the serial subtractor and the difference collector: serial
// inputs driven by the datapath, parallel result and status read back.
interface difference_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic             Start;
    logic             Sin;
    logic             Bin;
    logic [WIDTH-1:0] Dout;
    logic             Borrow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Sin, Bin,
        input  Dout, Borrow, Busy, Done
    );

    modport slave (
        input  Start, Sin, Bin,
        output Dout, Borrow, Busy, Done
    );
endinterface

// File: rtl/difference_shift_reg.sv
// Serial-in, parallel-out collector for the bit-serial subtractor. Gathers
// WIDTH difference bits (LSB first) plus the final borrow and publishes them
// as one word with a single-cycle Done strobe.
module difference_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     R,
    difference_shift_reg_if.slave    bus
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    // Next-state: arm on Start, shift while collecting, publish on the last bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        dout_d   = dout_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Sin/Bin are not looked at here, so an undriven stream cannot leak in.
                if (bus.Start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    dout_d   = {bus.Sin, sr_q[WIDTH-1:1]};
                    borrow_d = bus.Bin;
                    done_d   = 1'b1;
                    state_d  = bus.Start ? StShift : StIdle;
                    cnt_d    = '0;
                    sr_d     = '0;
                end else if (bus.Start) begin
                    // Restart mid-word: discard partial bits, keep last published word.
                    cnt_d = '0;
                    sr_d  = '0;
                end else begin
                    sr_d  = {bus.Sin, sr_q[WIDTH-1:1]};
                    cnt_d = CntW'(cnt_q + 1'b1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset that overrides everything.
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sr_q     <= '0;
            dout_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            dout_q   <= dout_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign bus.Dout   = dout_q;
    assign bus.Borrow = borrow_q;
    assign bus.Busy   = (state_q == StShift);
    assign bus.Done   = done_q;

endmodule

// File: tb/tb_difference_shift_reg.sv
// Bench for difference_shift_reg: an 8-bit and a 4-bit instance, a word-level
// reference model, a per-cycle compare process and literal expectations.
module tb_difference_shift_reg;

    logic CLK;
    logic R8, R4;

    difference_shift_reg_if #(.WIDTH(8)) bus8 ();
    difference_shift_reg_if #(.WIDTH(4)) bus4 ();

    difference_shift_reg #(.WIDTH(8)) dut8 (.CLK(CLK), .R(R8), .bus(bus8));
    difference_shift_reg #(.WIDTH(4)) dut4 (.CLK(CLK), .R(R4), .bus(bus4));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int done_cnt[2];

    // Reference model: number of bits collected and their accumulated value.
    bit       m_busy[2];
    int       m_n[2];
    logic [7:0] m_acc[2];
    logic [7:0] m_dout[2];
    bit       m_borrow[2];
    bit       m_done[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int i, input bit r, input bit st, input bit si,
                              input bit bi, input int w);
        if (r) begin
            m_busy[i] = 0; m_n[i] = 0; m_acc[i] = 0;
            m_dout[i] = 0; m_borrow[i] = 0; m_done[i] = 0;
        end else begin
            m_done[i] = 0;
            if (m_busy[i]) begin
                if (m_n[i] == w - 1) begin
                    m_dout[i]   = m_acc[i] | (8'(si) << (w - 1));
                    m_borrow[i] = bi;
                    m_done[i]   = 1;
                    m_busy[i]   = st;
                    m_n[i]      = 0;
                    m_acc[i]    = 0;
                end else if (st) begin
                    m_n[i]   = 0;
                    m_acc[i] = 0;
                end else begin
                    m_acc[i] = m_acc[i] | (8'(si) << m_n[i]);
                    m_n[i]   = m_n[i] + 1;
                end
            end else if (st) begin
                m_busy[i] = 1;
                m_n[i]    = 0;
                m_acc[i]  = 0;
            end
        end
    endtask

    // One clock edge: model advances with the inputs the DUT sampled.
    task automatic step();
        @(posedge CLK);
        model_edge(0, R8, bus8.Start, bus8.Sin, bus8.Bin, 8);
        model_edge(1, R4, bus4.Start, bus4.Sin, bus4.Bin, 4);
        #1;
    endtask

    task automatic drive(input int i, input bit st, input bit si, input bit bi);
        if (i == 0) begin
            bus8.Start = st; bus8.Sin = si; bus8.Bin = bi;
        end else begin
            bus4.Start = st; bus4.Sin = si; bus4.Bin = bi;
        end
    endtask

    // Optional Start edge, then the LSB-first stream; Bin rides with the last bit.
    task automatic send(input int i, input logic [7:0] word, input bit bin,
                        input bit do_start, input bit restart_last);
        int w;
        w = (i == 0) ? 8 : 4;
        if (do_start) begin
            drive(i, 1'b1, 1'b0, 1'b0);
            step();
        end
        for (int b = 0; b < w; b++) begin
            drive(i, (b == w - 1) && restart_last, word[b], (b == w - 1) ? bin : 1'b0);
            step();
        end
        drive(i, 1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("dout8",   32'(bus8.Dout),   32'(m_dout[0]));
            chk("borrow8", 32'(bus8.Borrow), 32'(m_borrow[0]));
            chk("busy8",   32'(bus8.Busy),   32'(m_busy[0]));
            chk("done8",   32'(bus8.Done),   32'(m_done[0]));
            chk("dout4",   32'(bus4.Dout),   32'(m_dout[1][3:0]));
            chk("borrow4", 32'(bus4.Borrow), 32'(m_borrow[1]));
            chk("busy4",   32'(bus4.Busy),   32'(m_busy[1]));
            chk("done4",   32'(bus4.Done),   32'(m_done[1]));
            if (bus8.Done) done_cnt[0]++;
            if (bus4.Done) done_cnt[1]++;
        end
    end

    initial begin
        done_cnt[0] = 0; done_cnt[1] = 0;
        R8 = 1'b1; R4 = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk_en = 1'b1;
        chk("rst_dout",  32'(bus8.Dout), 32'h00);
        chk("rst_busy",  32'(bus8.Busy), 32'h0);
        chk("rst_done",  32'(bus8.Done), 32'h0);
        R8 = 1'b0; R4 = 1'b0;

        // Idle with Sin toggling: nothing must happen.
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'b0, k[0], k[1]);
            drive(1, 1'b0, ~k[0], 1'b1);
            step();
        end
        chk("idle_dout",   32'(bus8.Dout),  32'h00);
        chk("idle_borrow", 32'(bus8.Borrow), 32'h0);
        chk("idle_dones",  32'(done_cnt[0]), 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0);

        // Single word 8'hA4.
        send(0, 8'hA4, 1'b0, 1'b1, 1'b0);
        chk("single_dout",   32'(bus8.Dout),   32'hA4);
        chk("single_borrow", 32'(bus8.Borrow), 32'h0);
        chk("single_done",   32'(bus8.Done),   32'h1);
        chk("single_busy",   32'(bus8.Busy),   32'h0);
        step();
        chk("single_done_off", 32'(bus8.Done), 32'h0);

        // Back-to-back: A4 then 6D with Start on the seam.
        send(0, 8'hA4, 1'b0, 1'b1, 1'b1);
        chk("b2b_dout1", 32'(bus8.Dout), 32'hA4);
        chk("b2b_done1", 32'(bus8.Done), 32'h1);
        chk("b2b_busy",  32'(bus8.Busy), 32'h1);
        send(0, 8'h6D, 1'b1, 1'b0, 1'b0);
        chk("b2b_dout2",   32'(bus8.Dout),   32'h6D);
        chk("b2b_borrow2", 32'(bus8.Borrow), 32'h1);
        chk("b2b_done2",   32'(bus8.Done),   32'h1);
        step();

        // Abort: 4 bits of FF, restart, full 3C.
        drive(0, 1'b1, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b0, 1'b1, 1'b1);
            step();
        end
        drive(0, 1'b1, 1'b1, 1'b0);
        step();
        chk("abort_hold_dout", 32'(bus8.Dout), 32'h6D);
        chk("abort_no_done",   32'(done_cnt[0]), 32'd3);
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("abort_dout", 32'(bus8.Dout), 32'h3C);
        chk("abort_done", 32'(bus8.Done), 32'h1);
        step();

        // Reset mid-collection.
        drive(0, 1'b1, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b0, 1'b1, 1'b1);
            step();
        end
        R8 = 1'b1;
        step();
        R8 = 1'b0;
        chk("midrst_dout", 32'(bus8.Dout), 32'h00);
        chk("midrst_busy", 32'(bus8.Busy), 32'h0);
        chk("midrst_done", 32'(bus8.Done), 32'h0);
        for (int k = 0; k < 9; k++) begin
            drive(0, 1'b0, 1'b1, 1'b1);
            step();
        end
        chk("midrst_ignore_dout", 32'(bus8.Dout), 32'h00);
        chk("midrst_ignore_busy", 32'(bus8.Busy), 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0);

        // WIDTH=4: stream 1,1,0,1 with Bin=1 -> 4'b1011.
        send(1, 8'h0B, 1'b1, 1'b1, 1'b0);
        chk("w4_dout",   32'(bus4.Dout),   32'hB);
        chk("w4_borrow", 32'(bus4.Borrow), 32'h1);
        chk("w4_done",   32'(bus4.Done),   32'h1);
        step();
        chk("done8_total", 32'(done_cnt[0]), 32'd4);
        chk("done4_total", 32'(done_cnt[1]), 32'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/difference_shift_reg.md
Name: difference_shift_reg

Overview:
Serial-in, parallel-out collector at the output end of the bit-serial subtract datapath. Operand shift registers emit one bit per CLK, LSB first. This block captures the serial difference stream plus the final borrow and assembles them into a WIDTH-bit parallel word. It publishes the word with a one-cycle Done strobe for downstream display and compare logic.

Parameters:
WIDTH, 8, number of serial bits per word (≥2)

Ports:
CLK  input  1  clock, all state updates on rising edge
R  input  1  synchronous active-high reset
Start  input  1  asserted in the same cycle as the operand-register load (L); arms collection
Sin  input  1  serial difference bit, LSB first, valid in the cycle after Start and for WIDTH cycles
Bin  input  1  borrow out of the serial subtractor; sampled together with the last bit
Dout  output  WIDTH  last completed difference word
Borrow  output  1  borrow captured with the last completed word
Busy  output  1  high while collecting bits
Done  output  1  one-cycle pulse when Dout/Borrow update

Behaviour:
- Reset (R=1 at an edge): state=IDLE, shift reg=0, count=0, Dout=0, Borrow=0, Busy=0, Done=0. R overrides every other input, including mid-collection.
- Internal: WIDTH-bit shift reg sr, counter cnt of width clog2(WIDTH), 2-state FSM IDLE/SHIFT.
- Busy = (state==SHIFT), registered.
- Done defaults to 0 every cycle unless set below.
- IDLE:
  - Start=1 -> SHIFT, cnt=0, sr=0.
  - Sin and Bin are ignored.
  - Dout and Borrow hold.
- SHIFT, each edge:
  - sr <= {Sin, sr[WIDTH-1:1]}, a right shift so the first bit ends at Dout[0].
  - cnt <= cnt+1.
- Completion, at the edge where cnt==WIDTH-1 in SHIFT:
  - Dout <= {Sin, sr[WIDTH-1:1]}.
  - Borrow <= Bin.
  - Done=1 for exactly the following cycle.
  - Next state is IDLE, unless Start=1 on this same edge: then the state stays SHIFT with cnt=0, sr=0. This is back-to-back operation with no gap and Done is still issued.
- Start=1 in SHIFT with cnt<WIDTH-1: abort and restart. cnt=0, sr=0, stay SHIFT. No Done. Dout and Borrow keep the previous completed word.
- Latency: Start sampled at edge k. Bits are sampled at edges k+1..k+WIDTH. Dout is valid and Done=1 after edge k+WIDTH.
- Dout changes only on completion or reset, never on partial data.
- Sin and Bin are sampled only on edges. X on Sin while IDLE must not propagate.

Test Plan:
- Reset then idle: R=1 for 2 edges, then R=0 with no Start for 10 edges, Sin toggling -> Dout=8'h00, Borrow=0, Busy=0, Done never asserted.
- Single word: Start at edge k with Sin stream 0,0,1,0,0,1,0,1 on edges k+1..k+8 and Bin=0 at k+8 -> Busy=1 after edges k..k+7; after edge k+8 Dout=8'b10100100, Borrow=0, Done=1 for one cycle, Busy=0.
- Back-to-back: word 8'hA4 immediately followed by Start on its last edge, then stream for 8'b01101101 with Bin=1 -> Done pulses after edges k+8 and k+16; Dout=8'hA4 then 8'h6D; Borrow=0 then 1; Busy stays 1 across the seam.
- Abort: Start, 4 bits of 8'hFF, then Start again, then full stream for 8'h3C -> no Done after the aborted partial word; Dout holds its prior value until one Done with Dout=8'h3C, 8 edges after the second Start.
- Reset mid-operation: Start, 5 bits, then R=1 for one edge -> next cycle Dout=0, Busy=0, Done=0. Further Sin is ignored until a new Start.
- WIDTH=4 instance: Start, then stream 1,1,0,1 with Bin=1 -> Dout=4'b1011, Borrow=1, Done after edge k+4.
